// File: rtl/ext_pipe_unit.sv
// Pipelined immediate-extension unit with a 2-entry result FIFO and valid/ready on both sides.
// Optional feature: define EXT_ILLEGAL_CHK_EN to add per-entry reserved-op flags and the illegal_o port.
module ext_pipe_unit #(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IMM_W-1:0] in_imm,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
`ifdef EXT_ILLEGAL_CHK_EN
    ,
    output logic             illegal_o
`endif
);

    localparam int DEPTH = 2;

    logic [1:0]       count_reg;
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [OUT_W-1:0] data_reg [DEPTH];
    logic [TAG_W-1:0] tag_reg  [DEPTH];

    logic             push;
    logic             pop;
    logic [1:0]       count_next;
    logic [OUT_W-1:0] sext_imm;
    logic [OUT_W-1:0] ext_result;

    assign in_ready  = (count_reg != 2'd2);
    assign out_valid = (count_reg != 2'd0);

    // A flush cycle neither stores the offered beat nor retires the head.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    assign sext_imm = {{(OUT_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};

    always_comb begin
        ext_result = '0;
        case (in_op)
            3'b000:  ext_result = {{(OUT_W-IMM_W){1'b0}}, in_imm};
            3'b001:  ext_result = sext_imm;
            3'b010:  ext_result = {in_imm, {(OUT_W-IMM_W){1'b0}}};
            3'b011:  ext_result = {sext_imm[OUT_W-3:0], 2'b00};
            3'b100:  ext_result = {{(OUT_W-8){1'b0}}, in_imm[7:0]};
            3'b101:  ext_result = {{(OUT_W-8){in_imm[7]}}, in_imm[7:0]};
            default: ext_result = '0;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count_reg + 2'd1;
                2'b01:   count_next = count_reg - 2'd1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (flush) begin
                wr_ptr_reg <= 1'b0;
                rd_ptr_reg <= 1'b0;
            end else begin
                if (push) wr_ptr_reg <= ~wr_ptr_reg;
                if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            end
        end
    end

    // Storage is cleared on reset so the head reads as zero while empty after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_reg[i] <= '0;
                tag_reg[i]  <= '0;
            end
        end else if (push) begin
            data_reg[wr_ptr_reg] <= ext_result;
            tag_reg[wr_ptr_reg]  <= in_tag;
        end
    end

    assign out_data = data_reg[rd_ptr_reg];
    assign out_tag  = tag_reg[rd_ptr_reg];

`ifdef EXT_ILLEGAL_CHK_EN
    logic ill_reg [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ill_reg[i] <= 1'b0;
        end else if (push) begin
            ill_reg[wr_ptr_reg] <= (in_op[2:1] == 2'b11);
        end
    end

    assign illegal_o = out_valid && ill_reg[rd_ptr_reg];
`endif

endmodule
